reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
Parametrised multi-read-port register file for the CPU datapath: DEPTH words of DATA_W bits, NUM_RD independent read ports and one write port.
- All ports use a per-access request/finish handshake, one cycle latency.
- Adds three behaviours:
  - a hardware clear sequence after reset, with a ready flag;
  - an optional hardwired zero register;
  - optional write-to-read bypass.
- Sits between the decode stage (read ports) and the write-back stage (write port).

Parameters:
- DATA_W, 32, word width in bits
- DEPTH, 32, number of registers; 2 ≤ DEPTH ≤ 2^ADDR_W
- ADDR_W, 5, address width per port
- NUM_RD, 2, number of read ports; 1..4
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes

Ports:
- clk  in  1  single clock; all state updates on posedge
- clrn  in  1  asynchronous active-low reset
- ready  out  1  high when the clear sequence is done and accesses are accepted
- re  in  NUM_RD  per-port read request
- read_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W]
- read_data  out  NUM_RD*DATA_W  packed read data; port i at [i*DATA_W +: DATA_W]
- read_finished  out  NUM_RD  per-port one-cycle pulse: read_data for that port is valid
- we  in  1  write request
- write_addr  in  ADDR_W  write address
- write_data  in  DATA_W  write data
- write_finished  out  1  one-cycle pulse: write committed
- addr_err  out  1  one-cycle pulse: an accepted access had an address ≥ DEPTH

Behaviour:
- Reset (clrn=0, asynchronous):
  - FSM goes to CLEAR and the clear counter goes to 0.
  - ready, read_finished, write_finished and addr_err go to 0; read_data goes to all-zero.
  - Array contents are not reset directly.
- FSM states:
  - CLEAR: on each posedge, write 0 to regs[cnt] and increment cnt. When cnt == DEPTH-1, write that entry, go to READY and set ready=1 on the same edge. The clear takes exactly DEPTH cycles after clrn deasserts.
  - READY: normal operation. It is left only by reset.
- In CLEAR:
  - re and we are ignored; no finished pulses and no array write from the write port.
  - clrn asserted mid-clear restarts the sequence from cnt=0.
- Read, port i, in READY:
  - If re[i]=1 at posedge t, then at t+1 read_data[i] holds the addressed value and read_finished[i]=1.
  - read_finished[i] is 0 at t+1 if re[i] was 0 at t.
  - read_data[i] holds its last value when not reading.
  - A held re[i] gives back-to-back reads, one per cycle.
- Write, in READY:
  - If we=1 at posedge t, regs[write_addr] is updated at t and write_finished=1 during t to t+1.
- Zero register: with ZERO_REG=1, reads of address 0 return 0 and writes to address 0 are dropped. write_finished still pulses.
- Out-of-range addresses (addr ≥ DEPTH):
  - Reads return 0 with read_finished=1; writes are dropped with write_finished=1.
  - addr_err pulses for one cycle, the cycle after the access, and is the OR over all ports.
- Simultaneous read and write to the same address in one cycle: the result is set by the optional feature below.
- Multiple read ports may use the same address in the same cycle; each gets identical data.
- No back-pressure: requests are never stalled once ready=1.

Optional Feature:
Macro: REG_FILE_BYPASS_EN.
- Defined: a read of address A in the same cycle as an accepted write to A returns write_data, i.e. the new value. Exceptions: A=0 with ZERO_REG=1, or A ≥ DEPTH; these still return 0.
- Undefined: such a read returns the value before the write (read-before-write).
- Write behaviour and latency are identical either way.

Decomposition:
- Package reg_file_pkg holds:
  - the default-width constants (DATA_W_DEF=32, DEPTH_DEF=32, ADDR_W_DEF=5);
  - the FSM state enum {RF_CLEAR, RF_READY};
  - a helper that extracts port i from the packed buses.
- Sub-module reg_file_rd_port, instantiated NUM_RD times by generate:
  - takes the array word, write-port signals, re and addr;
  - applies zero-register, range check and bypass selection;
  - registers read_data/read_finished and the per-port error bit.
- Array, clear FSM and write port stay in the top.

Test Plan:
- Release clrn at cycle 0, DEPTH=32 → ready=0 for cycles 0–31, ready=1 from cycle 32; then a read of every address returns 0x00000000.
- Write 0xDEADBEEF to r5, next cycle read r5 on port 0 and r5 on port 1 → both return 0xDEADBEEF with read_finished=2'b11 one cycle later; write_finished pulses once.
- Write 0x12345678 to r0 with ZERO_REG=1, then read r0 → 0x00000000 and write_finished=1.
- r7=0x1, then the same cycle writes r7=0x2 and reads r7 → 0x2 with REG_FILE_BYPASS_EN defined, 0x1 without; the following read → 0x2 in both builds.
- DEPTH=24, read addr 30 and write addr 28 → read_data=0, addr_err pulses once; a later read of every address 0–23 shows no corruption.
- Assert clrn during CLEAR at cnt=10 with we=1 → the clear restarts, ready stays 0 for a further DEPTH cycles, and no write_finished occurs.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-read-port register file: default widths,
// clear-sequencer state type and a packed-bus field extractor.
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 32;
    localparam int ADDR_W_DEF = 5;

    // Widest packed bus the field extractor accepts (NUM_RD * width).
    localparam int BUS_MAX_W  = 256;

    typedef enum logic {
        RF_CLEAR,
        RF_READY
    } rf_state_e;

    // Returns field idx of a packed bus; the caller truncates to its width.
    function automatic logic [BUS_MAX_W-1:0] port_field(
        input logic [BUS_MAX_W-1:0] bus,
        input int unsigned          idx,
        input int unsigned          width
    );
        return bus >> (idx * width);
    endfunction

endpackage : reg_file_pkg

// File: rtl/reg_file_rd_port.sv
// One read port: zero-register, range check and optional write bypass
// (REG_FILE_BYPASS_EN), with registered data, finish pulse and error bit.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              en,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] word,
`ifdef REG_FILE_BYPASS_EN
    input  logic              we_acc,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
`endif
    output logic [DATA_W-1:0] read_data,
    output logic              read_finished,
    output logic              addr_err
);

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic              acc;
    logic              in_range;
    logic              is_zero;
    logic [DATA_W-1:0] src_word;
    logic [DATA_W-1:0] sel_data;

    assign acc      = en & re;
    assign in_range = {1'b0, addr} < DEPTH_LIM;
    assign is_zero  = (ZERO_REG != 0) && (addr == '0);

`ifdef REG_FILE_BYPASS_EN
    // Same-cycle write to this address forwards the new value.
    assign src_word = (we_acc && (write_addr == addr)) ? write_data : word;
`else
    assign src_word = word;
`endif

    assign sel_data = (!in_range || is_zero) ? '0 : src_word;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            read_data     <= '0;
            read_finished <= 1'b0;
            addr_err      <= 1'b0;
        end else begin
            read_finished <= acc;
            addr_err      <= acc & ~in_range;
            if (acc) begin
                read_data <= sel_data;
            end
        end
    end

endmodule : reg_file_rd_port

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with post-reset hardware clear, optional zero
// register and optional write-to-read bypass (macro REG_FILE_BYPASS_EN).
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     clrn,
    output logic                     ready,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] read_addr,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    output logic [NUM_RD-1:0]        read_finished,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        write_addr,
    input  logic [DATA_W-1:0]        write_data,
    output logic                     write_finished,
    output logic                     addr_err
);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    rf_state_e         state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic [DATA_W-1:0] regs [DEPTH];

    logic              wr_acc;
    logic              wr_in_range;
    logic              wr_zero;
    logic              wr_commit;
    logic              wr_fin_q;
    logic              wr_err_q;
    logic [NUM_RD-1:0] rd_err;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= RF_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: defaults first, so no path through this block leaves a signal
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == RF_CLEAR) begin
            cnt_nxt = cnt + ADDR_W'(1);
            if (cnt == LAST_IDX) begin
                state_nxt = RF_READY;
                cnt_nxt   = '0;
            end
        end
    end

    assign ready       = (state == RF_READY);
    assign wr_acc      = ready & we;
    assign wr_in_range = {1'b0, write_addr} < DEPTH_LIM;
    assign wr_zero     = (ZERO_REG != 0) && (write_addr == '0);
    assign wr_commit   = wr_acc & wr_in_range & ~wr_zero;

    // NOTE: the array has no reset branch; the clear sequencer zeroes it one
    // entry per cycle, which keeps it mappable to plain RAM/flop arrays.
    always_ff @(posedge clk) begin
        if (state == RF_CLEAR) begin
            regs[cnt] <= '0;
        end else if (wr_commit) begin
            regs[write_addr] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_fin_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            wr_fin_q <= wr_acc;
            wr_err_q <= wr_acc & ~wr_in_range;
        end
    end

    assign write_finished = wr_fin_q;
    assign addr_err       = wr_err_q | (|rd_err);

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;

        assign rd_addr = ADDR_W'(port_field(BUS_MAX_W'(read_addr), i, ADDR_W));

        reg_file_rd_port #(
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .clk           (clk),
            .clrn          (clrn),
            .en            (ready),
            .re            (re[i]),
            .addr          (rd_addr),
            .word          (regs[rd_addr]),
`ifdef REG_FILE_BYPASS_EN
            .we_acc        (wr_acc),
            .write_addr    (write_addr),
            .write_data    (write_data),
`endif
            .read_data     (read_data[i*DATA_W +: DATA_W]),
            .read_finished (read_finished[i]),
            .addr_err      (rd_err[i])
        );
    end

endmodule : reg_file_mp

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: directed scenarios plus random traffic
// checked against an array-based reference model.
module tb_reg_file_mp;

    localparam int DATA_W   = 32;
    localparam int DEPTH    = 24;
    localparam int ADDR_W   = 5;
    localparam int NUM_RD   = 2;
    localparam int ZERO_REG = 1;

    logic                     clk = 1'b0;
    logic                     clrn = 1'b0;
    logic                     ready;
    logic [NUM_RD-1:0]        re = '0;
    logic [NUM_RD*ADDR_W-1:0] read_addr = '0;
    logic [NUM_RD*DATA_W-1:0] read_data;
    logic [NUM_RD-1:0]        read_finished;
    logic                     we = 1'b0;
    logic [ADDR_W-1:0]        write_addr = '0;
    logic [DATA_W-1:0]        write_data = '0;
    logic                     write_finished;
    logic                     addr_err;

    always #5 clk = ~clk;

    reg_file_mp #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) dut (
        .clk            (clk),
        .clrn           (clrn),
        .ready          (ready),
        .re             (re),
        .read_addr      (read_addr),
        .read_data      (read_data),
        .read_finished  (read_finished),
        .we             (we),
        .write_addr     (write_addr),
        .write_data     (write_data),
        .write_finished (write_finished),
        .addr_err       (addr_err)
    );

    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              rd_q [NUM_RD][$];
    int                wr_q [$];
    int                err_q [$];
    logic [DATA_W-1:0] mdl [DEPTH];
    logic [DATA_W-1:0] last_rd [NUM_RD];

    int cyc    = 0;
    int edges  = 0;
    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Clock edges seen since reset release; the clear needs DEPTH of them.
    always @(posedge clk or negedge clrn) begin
        if (!clrn) edges <= 0;
        else       edges <= edges + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_read(input int a, input logic w, input int wa,
                                                     input logic [DATA_W-1:0] wd);
        if (a >= DEPTH) return '0;
        if (ZERO_REG != 0 && a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
        if (w && wa == a) return wd;
`else
        if (w && wa == a) return mdl[a];
`endif
        return mdl[a];
    endfunction

    // Monitor: compares outputs against the expectation queues every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            bit   pend;
            exp_t e;
            check("ready", 64'(ready), 64'(edges >= DEPTH));
            for (int i = 0; i < NUM_RD; i++) begin
                pend = (rd_q[i].size() > 0) && (rd_q[i][0].cyc == cyc);
                check($sformatf("read_finished[%0d]", i), 64'(read_finished[i]), 64'(pend));
                if (pend) begin
                    e = rd_q[i].pop_front();
                    last_rd[i] = e.data;
                end
                check($sformatf("read_data[%0d]", i), 64'(read_data[i*DATA_W +: DATA_W]),
                      64'(last_rd[i]));
            end
            pend = (wr_q.size() > 0) && (wr_q[0] == cyc);
            check("write_finished", 64'(write_finished), 64'(pend));
            if (pend) void'(wr_q.pop_front());
            pend = (err_q.size() > 0) && (err_q[0] == cyc);
            check("addr_err", 64'(addr_err), 64'(pend));
            if (pend) void'(err_q.pop_front());
        end
    end

    // Drives one cycle of stimulus and records what the DUT must answer.
    task automatic drive(input logic [NUM_RD-1:0] r, input int a0, input int a1,
                         input logic w, input int wa, input logic [DATA_W-1:0] wd);
        int   ra [NUM_RD];
        bit   acc;
        bit   err;
        exp_t e;
        @(negedge clk);
        #1;
        ra[0]      = a0;
        ra[1]      = a1;
        re         = r;
        read_addr  = {ADDR_W'(a1), ADDR_W'(a0)};
        we         = w;
        write_addr = ADDR_W'(wa);
        write_data = wd;
        acc        = clrn && (edges >= DEPTH);
        err        = 1'b0;
        if (acc) begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (r[i]) begin
                    e.cyc  = cyc + 1;
                    e.data = model_read(ra[i], w, wa, wd);
                    rd_q[i].push_back(e);
                    if (ra[i] >= DEPTH) err = 1'b1;
                end
            end
            if (w) begin
                wr_q.push_back(cyc + 1);
                if (wa >= DEPTH) err = 1'b1;
                else if (!(ZERO_REG != 0 && wa == 0)) mdl[wa] = wd;
            end
            if (err) err_q.push_back(cyc + 1);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive('0, 0, 0, 1'b0, 0, '0);
    endtask

    task automatic set_reset(input logic level);
        @(negedge clk);
        #1;
        clrn = level;
        if (!level) begin
            for (int i = 0; i < NUM_RD; i++) begin
                rd_q[i].delete();
                last_rd[i] = '0;
            end
            wr_q.delete();
            err_q.delete();
            for (int a = 0; a < DEPTH; a++) mdl[a] = '0;
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) drive(2'b11, a, DEPTH - 1 - a, 1'b0, 0, '0);
    endtask

    task automatic random_traffic(input int n);
        int a0, a1, wa;
        for (int k = 0; k < n; k++) begin
            a0 = int'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? a0 : int'($urandom_range(0, 31));
            wa = ($urandom_range(0, 2) == 0) ? a0 : int'($urandom_range(0, 31));
            drive(NUM_RD'($urandom), a0, a1, 1'($urandom), wa, $urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_RD; i++) last_rd[i] = '0;
        for (int a = 0; a < DEPTH; a++) mdl[a] = '0;
        mon_en = 1'b1;
        idle(3);

        // Release, then reset again mid-clear while a write is requested.
        set_reset(1'b1);
        for (int k = 0; k < 10; k++) drive(2'b11, k, k, 1'b1, 3, 32'hBAD0_0000 + k);
        set_reset(1'b0);
        drive(2'b11, 1, 2, 1'b1, 3, 32'h5555_AAAA);
        set_reset(1'b1);
        for (int k = 0; k < DEPTH; k++) drive(2'b01, 3, 3, 1'b1, 3, 32'h0BAD_F00D);
        idle(2);

        read_all();

        drive('0, 0, 0, 1'b1, 5, 32'hDEAD_BEEF);
        drive(2'b11, 5, 5, 1'b0, 0, '0);

        drive('0, 0, 0, 1'b1, 0, 32'h1234_5678);
        drive(2'b01, 0, 0, 1'b0, 0, '0);

        drive('0, 0, 0, 1'b1, 7, 32'h1);
        drive(2'b11, 7, 7, 1'b1, 7, 32'h2);
        drive(2'b11, 7, 7, 1'b0, 0, '0);

        drive(2'b01, 30, 0, 1'b1, 28, 32'hAAAA_5555);
        idle(1);
        read_all();

        random_traffic(1500);

        // Reset during traffic clears outputs; a fresh clear follows.
        set_reset(1'b0);
        idle(2);
        set_reset(1'b1);
        idle(DEPTH + 1);
        read_all();
        random_traffic(400);
        idle(3);

        for (int i = 0; i < NUM_RD; i++) check($sformatf("rd_q[%0d] drained", i), 64'(rd_q[i].size()), 64'd0);
        check("wr_q drained", 64'(wr_q.size()), 64'd0);
        check("err_q drained", 64'(err_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_file_mp
